// File: rtl/pipe_tree_pkg.sv
// pipe_tree_pkg: width helpers and legal LOG2_N range
// shared by the pipelined reduction adder.
package pipe_tree_pkg;

  localparam int LOG2_N_MIN = 1;
  localparam int LOG2_N_MAX = 10;

  // Width of the values held after tree level k (k=0 is the abs pre-stage).
  function automatic int stage_w(input int in_w, input int k);
    return in_w + k + 1;
  endfunction

  function automatic int sum_w(input int in_w, input int log2n);
    return stage_w(in_w, log2n);
  endfunction

endpackage

// File: rtl/pipe_tree_level.sv
// pipe_tree_level: one registered level of the reduction tree,
// summing index-adjacent pairs of W-bit signed values into W+1 bits.
module pipe_tree_level #(
  parameter int W     = 10,
  parameter int PAIRS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic [2*PAIRS*W-1:0]   d_i,
  output logic                   valid_o,
  output logic [PAIRS*(W+1)-1:0] q_o
);

  logic [PAIRS*(W+1)-1:0] sum_d;
  logic [PAIRS*(W+1)-1:0] sum_q;
  logic                   valid_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < PAIRS; i++) begin
      sum_d[i*(W+1) +: W+1] =
        {d_i[2*i*W+W-1], d_i[2*i*W +: W]} +
        {d_i[(2*i+1)*W+W-1], d_i[(2*i+1)*W +: W]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      sum_q   <= sum_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = sum_q;

endmodule

// File: rtl/pipe_tree_adder.sv
// pipe_tree_adder: pipelined signed/abs reduction of 2**LOG2_N operands.
// Define PIPE_TREE_ACC_EN for the in_first port and output accumulator.
module pipe_tree_adder
  import pipe_tree_pkg::*;
#(
  parameter int  IN_W   = 9,
  parameter int  LOG2_N = 8,
  parameter int  ACC_W  = IN_W + LOG2_N + 1 + 8,
  localparam int N      = 2 ** LOG2_N,
  localparam int SUM_W  = sum_w(IN_W, LOG2_N),
`ifdef PIPE_TREE_ACC_EN
  localparam int OUT_W  = ACC_W
`else
  localparam int OUT_W  = SUM_W
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_abs,
`ifdef PIPE_TREE_ACC_EN
  input  logic                   in_first,
`endif
  input  logic signed [IN_W-1:0] operand [N],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [OUT_W-1:0] out_sum
);

  if (LOG2_N < LOG2_N_MIN || LOG2_N > LOG2_N_MAX || ACC_W < SUM_W) begin : g_bad_cfg
    $error("pipe_tree_adder: illegal LOG2_N or ACC_W");
  end

  // Global advance: the whole pipe moves or the whole pipe holds.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Width IN_W+1 keeps abs(-2**(IN_W-1)) exact.
  function automatic logic [IN_W:0] pre(input logic [IN_W-1:0] op,
                                        input logic ab);
    logic [IN_W:0] x;
    x = {op[IN_W-1], op};
    return (ab && x[IN_W]) ? -x : x;
  endfunction

  logic [N*(IN_W+1)-1:0] s0_d;
  logic [N*(IN_W+1)-1:0] s0_q;
  logic                  v0_q;

  always_comb begin
    s0_d = '0;
    for (int i = 0; i < N; i++) begin
      s0_d[i*(IN_W+1) +: IN_W+1] = pre(operand[i], in_abs);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      s0_q <= '0;
    end else if (adv) begin
      v0_q <= in_valid;
      s0_q <= s0_d;
    end
  end

  for (genvar k = 1; k <= LOG2_N; k++) begin : g_lvl
    localparam int W = IN_W + k;
    localparam int P = N >> k;
    logic [2*P*W-1:0] d;
    logic             vi;
    logic [P*(W+1)-1:0] q;
    logic             v;
    if (k == 1) begin : g_src
      assign d  = s0_q;
      assign vi = v0_q;
    end else begin : g_src
      assign d  = g_lvl[k-1].q;
      assign vi = g_lvl[k-1].v;
    end
    pipe_tree_level #(
      .W     (W),
      .PAIRS (P)
    ) u_lvl (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (adv),
      .valid_i (vi),
      .d_i     (d),
      .valid_o (v),
      .q_o     (q)
    );
  end

  logic [SUM_W-1:0] tree_q;
  logic             tree_v;
  assign tree_q = g_lvl[LOG2_N].q;
  assign tree_v = g_lvl[LOG2_N].v;

`ifdef PIPE_TREE_ACC_EN
  logic [LOG2_N:0]  first_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;
  logic             acc_v_q;

  // in_first travels alongside its beat, one bit per stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= '0;
    end else if (adv) begin
      first_q <= {first_q[LOG2_N-1:0], in_first};
    end
  end

  assign acc_d = first_q[LOG2_N] ? ACC_W'($signed(tree_q))
                                 : acc_q + ACC_W'($signed(tree_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      acc_v_q <= 1'b0;
    end else if (adv) begin
      acc_v_q <= tree_v;
      if (tree_v) acc_q <= acc_d;
    end
  end

  assign out_valid = acc_v_q;
  assign out_sum   = acc_q;
`else
  assign out_valid = tree_v;
  assign out_sum   = tree_q;
`endif

endmodule
